div_sequencer: RTL and testbench

Sequential unsigned restoring divider built around a control FSM that sequences load/shift/subtract steps on a combined remainder:quotient shift register.
Sits in the division_devices group as the controller that owns and drives the shift-register datapath. Upstream logic uses it through a start/busy/done handshake.
One bit of quotient is resolved per SHIFT+SUB step pair.

---
 rtl/div_pkg.sv | 5 +
 rtl/div_sequencer_if.sv | 23 ++
 rtl/div_sequencer_shreg.sv | 20 ++
 rtl/div_sequencer.sv | 107 ++++++++++
 tb/tb_div_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the division sequencer
package div_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, SUB, ZERO, DONE, STEP} div_state_t;
  localparam int DIV_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: start/busy/done handshake plus operand and result bus
interface div_sequencer_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sequencer_shreg.sv
// div_sequencer_shreg: parameterised register with parallel load and one-bit shift
module div_sequencer_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic             shift_dir,
  input  logic             sl,
  input  logic             sr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // load wins over shift; shift_dir=0 shifts left taking sl into bit 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load_en) q <= d;
    else if (shift_en) q <= shift_dir ? {sr, q[WIDTH-1:1]} : {q[WIDTH-2:0], sl};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: restoring unsigned divider; DIV_SEQ_FAST_STEP_EN merges SHIFT+SUB into one STEP state
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  div_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  div_state_t state, state_n;
  logic [WIDTH:0] a, a_in, a_res;
  logic [WIDTH-1:0] m, q, q_d, q_res, quotient, remainder;
  logic [CW-1:0] count;
  logic [WIDTH+1:0] diff;
  logic borrow, last, q_load, q_shift, div_by_zero;
`ifdef DIV_SEQ_FAST_STEP_EN
  localparam div_state_t RUN = STEP;
  assign a_in  = {a[WIDTH-1:0], q[WIDTH-1]};
  assign q_res = {q[WIDTH-2:0], ~borrow};
`else
  localparam div_state_t RUN = SHIFT;
  assign a_in  = a;
  assign q_res = {q[WIDTH-1:1], ~borrow};
`endif
  assign diff   = {1'b0, a_in} - {2'b00, m};
  assign borrow = diff[WIDTH+1];
  assign a_res  = borrow ? a_in : diff[WIDTH:0];
  assign last   = count == CW'(1);
  assign bus.busy        = state != IDLE;
  assign bus.done        = state == DONE;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;
  div_sequencer_shreg #(.WIDTH(WIDTH)) u_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (q_load),
    .shift_en (q_shift),
    .shift_dir(1'b0),
    .sl       (1'b0),
    .sr       (1'b0),
    .d        (q_d),
    .q        (q)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state and Q register control; arithmetic states reload Q with the new quotient bit
  always_comb begin
    state_n = state;
    q_load  = 1'b0;
    q_shift = 1'b0;
    q_d     = q_res;
    case (state)
      IDLE: if (bus.start) begin
        state_n = bus.divisor != '0 ? RUN : ZERO;
        q_load  = 1'b1;
        q_d     = bus.dividend;
      end
      SHIFT: begin
        state_n = SUB;
        q_shift = 1'b1;
      end
      SUB, STEP: begin
        state_n = last ? DONE : RUN;
        q_load  = 1'b1;
      end
      ZERO: state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // partial remainder, divisor, step counter and result registers loaded on DONE entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a           <= '0;
      m           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        a     <= '0;
        m     <= bus.divisor;
        count <= CW'(WIDTH);
      end
      if (state == SHIFT) a <= {a[WIDTH-1:0], q[WIDTH-1]};
      if (state == SUB || state == STEP) begin
        a     <= a_res;
        count <= count - 1'b1;
        if (last) begin
          quotient    <= q_res;
          remainder   <= a_res[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
      if (state == ZERO) begin
        quotient    <= '1;
        remainder   <= q;
        div_by_zero <= 1'b1;
      end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard-driven bench for div_sequencer
module tb_div_sequencer;
  import div_pkg::*;
  localparam int W = 8;
`ifdef DIV_SEQ_FAST_STEP_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = 2 * W + 1;
`endif
  typedef struct {
    logic [W-1:0] dvd, dvs, q, r;
    logic z;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  div_sequencer_if #(.WIDTH(W)) bus ();
  div_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = dvd;
    bus.divisor = dvs;
    e.dvd = dvd;
    e.dvs = dvs;
    e.z = dvs == 0;
    e.q = dvs == 0 ? 8'hFF : dvd / dvs;
    e.r = dvs == 0 ? dvd : dvd % dvs;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic b1);
    lat = 0;
    b1 = 1'b0;
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(negedge clk);
      if (i == 1) b1 = bus.busy;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.quotient !== 8'h00) begin bad++; $display("FAIL reset_quotient: got %h want 00", bus.quotient); end
    total++; if (bus.remainder !== 8'h00) begin bad++; $display("FAIL reset_remainder: got %h want 00", bus.remainder); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic b1;
    exp_t e;
    issue(100, 7);
    wait_done(lat, b1);
    e = sb.pop_front();
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", b1); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    total++; if (bus.quotient !== e.q) begin bad++; $display("FAIL basic_quotient: got %0d want %0d", bus.quotient, e.q); end
    total++; if (bus.remainder !== e.r) begin bad++; $display("FAIL basic_remainder: got %0d want %0d", bus.remainder, e.r); end
    total++; if (bus.div_by_zero !== e.z) begin bad++; $display("FAIL basic_dbz: got %b want %b", bus.div_by_zero, e.z); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic b1;
    exp_t e;
    issue(255, 1);
    wait_done(lat, b1);
    e = sb.pop_front();
    total++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin bad++; $display("FAIL b2b_first: got %0d r %0d want %0d r %0d", bus.quotient, bus.remainder, e.q, e.r); end
    issue(5, 9);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      if (bus.quotient !== 8'd255 || bus.remainder !== 8'd0) begin
        total++; bad++;
        $display("FAIL b2b_hold: got %0d r %0d want 255 r 0 at cycle %0d", bus.quotient, bus.remainder, i);
      end
    end
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_early_done: got %b want 0", bus.done); end
    @(negedge clk);
    e = sb.pop_front();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_latency: done got %b want 1", bus.done); end
    total++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin bad++; $display("FAIL b2b_second: got %0d r %0d want %0d r %0d", bus.quotient, bus.remainder, e.q, e.r); end
  endtask

  task automatic test_zero;
    int lat;
    logic b1;
    exp_t e;
    issue(42, 0);
    wait_done(lat, b1);
    e = sb.pop_front();
    total++; if (lat !== 2) begin bad++; $display("FAIL zero_latency: got %0d want 2", lat); end
    total++; if (bus.quotient !== e.q) begin bad++; $display("FAIL zero_quotient: got %h want %h", bus.quotient, e.q); end
    total++; if (bus.remainder !== e.r) begin bad++; $display("FAIL zero_remainder: got %0d want %0d", bus.remainder, e.r); end
    total++; if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL zero_dbz: got %b want 1", bus.div_by_zero); end
    issue(10, 3);
    wait_done(lat, b1);
    e = sb.pop_front();
    total++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin bad++; $display("FAIL zero_next: got %0d r %0d want %0d r %0d", bus.quotient, bus.remainder, e.q, e.r); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL zero_next_dbz: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_busy_ignore;
    int ndone;
    exp_t e;
    ndone = 0;
    issue(200, 13);
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin bad++; $display("FAIL ignore_result: got %0d r %0d want %0d r %0d", bus.quotient, bus.remainder, e.q, e.r); end
        end
      end
      if (i == 2 || bus.done) begin
        bus.start = 1'b1;
        bus.dividend = 9;
        bus.divisor = 2;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    @(negedge clk);
    total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int ndone;
    logic b1;
    exp_t e;
    issue(100, 7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    total++; if (bus.quotient !== 8'h00 || bus.remainder !== 8'h00 || bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL midrst_outputs: got %h %h %b want 00 00 0", bus.quotient, bus.remainder, bus.div_by_zero); end
    ndone = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", ndone); end
    rst_n = 1'b1;
    issue(100, 7);
    wait_done(lat, b1);
    e = sb.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
    total++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin bad++; $display("FAIL midrst_rerun: got %0d r %0d want %0d r %0d", bus.quotient, bus.remainder, e.q, e.r); end
  endtask

  task automatic test_random;
    int lat;
    logic b1;
    exp_t e;
    logic [W-1:0] dvd, dvs;
    for (int n = 0; n < 1000; n++) begin
      dvs = W'($urandom_range(1, 255));
      dvd = (n % 10 == 0) ? '0 : (n % 4 == 1) ? W'($urandom_range(0, int'(dvs) - 1)) : W'($urandom_range(0, 255));
      issue(dvd, dvs);
      wait_done(lat, b1);
      e = sb.pop_front();
      total++;
      if (lat !== LAT || bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL rand_model: %0d/%0d got %0d r %0d z %b lat %0d want %0d r %0d z 0 lat %0d", e.dvd, e.dvs, bus.quotient, bus.remainder, bus.div_by_zero, lat, e.q, e.r, LAT);
      end
      total++;
      if (int'(bus.quotient) * int'(e.dvs) + int'(bus.remainder) != int'(e.dvd) || bus.remainder >= e.dvs) begin
        bad++;
        $display("FAIL rand_invariant: %0d/%0d got %0d r %0d", e.dvd, e.dvs, bus.quotient, bus.remainder);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_zero;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
